// File: rtl/ex_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common (package)
//  Description : Shared types for the execute-stage issue queue. Holds the
//                decoded control bundle (control_type) and the queue entry
//                record (ex_entry_t), whose operand width is set by EX_XLEN.
//  Contents    : alu_op_e, control_type, EX_XLEN, ex_entry_t
//  Revision    : 1.0 - initial release
// ============================================================================
package common;

    // Operand / PC width used by the stored entry record.
    localparam int EX_XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    src_imm;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    branch;
    } control_type;

    // One issue-queue entry; all fields travel together through the queue.
    typedef struct packed {
        logic [EX_XLEN-1:0] data1;
        logic [EX_XLEN-1:0] data2;
        logic [EX_XLEN-1:0] immediate;
        control_type        control;
        logic               compflg;
        logic [EX_XLEN-1:0] pc;
    } ex_entry_t;

endpackage : common
`default_nettype wire

// File: rtl/ex_issue_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_issue_queue_if
//  Description : Upstream (in_*) and downstream (out_*) handshake bundle of
//                the execute issue queue.
//  Modports    : master - producer/consumer side driving in_* and out_ready
//                slave  - the queue itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_issue_queue_if
    import common::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data1;
    logic [XLEN-1:0] in_data2;
    logic [XLEN-1:0] in_immediate;
    logic [XLEN-1:0] in_pc;
    control_type     in_control;
    logic            in_compflg;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data1;
    logic [XLEN-1:0] out_data2;
    logic [XLEN-1:0] out_immediate;
    logic [XLEN-1:0] out_pc;
    control_type     out_control;
    logic            out_compflg;

    modport master (
        output in_valid, in_data1, in_data2, in_immediate, in_pc, in_control,
               in_compflg, out_ready,
        input  in_ready, out_valid, out_data1, out_data2, out_immediate,
               out_pc, out_control, out_compflg
    );

    modport slave (
        input  in_valid, in_data1, in_data2, in_immediate, in_pc, in_control,
               in_compflg, out_ready,
        output in_ready, out_valid, out_data1, out_data2, out_immediate,
               out_pc, out_control, out_compflg
    );

endinterface : ex_issue_queue_if
`default_nettype wire

// File: rtl/ex_queue_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ex_queue_ram
//  Description : DEPTH x WIDTH storage array, one synchronous write port and
//                one asynchronous read port. Contents are never cleared.
//  Ports       : clk            - clock
//                wr_en/wr_addr/wr_data - write port (rising edge)
//                rd_addr/rd_data       - combinational read port
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             wr_en,
    input  wire logic [AW-1:0]    wr_addr,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic [AW-1:0]    rd_addr,
    output logic      [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : ex_queue_ram
`default_nettype wire

// File: rtl/ex_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : ex_issue_queue
//  Description : In-order FIFO issue queue in front of the execute stage.
//                Ready/valid on both sides, flush on branch redirect, no
//                same-cycle bypass from input to output.
//  Ports       : clk, rst_n     - clock, synchronous active-low reset
//                flush          - drop every stored entry at the next edge
//                q_if (slave)   - in_* push side, out_* head side
//                occupancy      - number of stored entries
//                almost_full    - occupancy >= DEPTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_issue_queue
    import common::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       flush,
    ex_issue_queue_if.slave                 q_if,
    output logic [$clog2(DEPTH+1)-1:0]      occupancy,
    output logic                            almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = $bits(ex_entry_t);

    localparam logic [CW-1:0] c_full       = CW'(DEPTH);
    localparam logic [CW-1:0] c_almost     = CW'(DEPTH - 1);
    localparam logic [PW-1:0] c_ptr_one    = PW'(1);
    localparam logic [CW-1:0] c_cnt_one    = CW'(1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;
    ex_entry_t     w_wr_entry;
    ex_entry_t     w_rd_entry;
    ex_entry_t     w_head;
    logic [EW-1:0] w_rd_bits;

    // Handshake flags come from the count register only, so in_ready never
    // depends on out_ready in the same cycle.
    assign w_not_empty   = (r_count != '0);
    assign q_if.in_ready = (r_count != c_full);
    assign q_if.out_valid = w_not_empty;

    // Flush (and reset) suppress the handshakes so nothing moves that cycle.
    assign w_push = q_if.in_valid && q_if.in_ready && rst_n && !flush;
    assign w_pop  = w_not_empty && q_if.out_ready && rst_n && !flush;

    always_comb begin
        w_wr_entry           = '0;
        w_wr_entry.data1     = q_if.in_data1[XLEN-1:0];
        w_wr_entry.data2     = q_if.in_data2[XLEN-1:0];
        w_wr_entry.immediate = q_if.in_immediate[XLEN-1:0];
        w_wr_entry.control   = q_if.in_control;
        w_wr_entry.compflg   = q_if.in_compflg;
        w_wr_entry.pc        = q_if.in_pc[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural rollover is the modulo wrap.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    ex_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_entry),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_bits)
    );

    assign w_rd_entry = ex_entry_t'(w_rd_bits);

    // Stale storage is never cleared; an empty queue presents all zeros.
    assign w_head = w_not_empty ? w_rd_entry : '0;

    assign q_if.out_data1     = w_head.data1;
    assign q_if.out_data2     = w_head.data2;
    assign q_if.out_immediate = w_head.immediate;
    assign q_if.out_control   = w_head.control;
    assign q_if.out_compflg   = w_head.compflg;
    assign q_if.out_pc        = w_head.pc;

    assign occupancy   = r_count;
    assign almost_full = (r_count >= c_almost);

endmodule : ex_issue_queue
`default_nettype wire
